// File: rtl/rolling_volatility_pkg.sv
// Shared widths, per-stock state record and mid-price helper for the rolling volatility engine.
// Storage widths are sized for the largest supported window and price width.
package rolling_volatility_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_STOCKS  = 4;
    localparam int DEF_WINDOW_LOG2 = 4;

    // Upper bounds for the top-level parameters; the state record is sized to these.
    localparam int MAX_DATA_WIDTH  = 32;
    localparam int MAX_WINDOW_LOG2 = 8;

    localparam int PTR_W = MAX_WINDOW_LOG2;
    localparam int CNT_W = MAX_WINDOW_LOG2 + 1;
    localparam int SUM_W = MAX_DATA_WIDTH + MAX_WINDOW_LOG2;
    localparam int SQ_W  = 2 * MAX_DATA_WIDTH + MAX_WINDOW_LOG2;

    typedef struct packed {
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;
        logic [SUM_W-1:0] sum;
        logic [SQ_W-1:0]  sq;
    } stock_state_t;

    // The extra carry bit keeps (ask + bid) / 2 exact for full-scale prices.
    function automatic logic [MAX_DATA_WIDTH-1:0] mid_price(
        input logic [MAX_DATA_WIDTH-1:0] ask,
        input logic [MAX_DATA_WIDTH-1:0] bid
    );
        logic [MAX_DATA_WIDTH:0] total;
        total = {1'b0, ask} + {1'b0, bid};
        return MAX_DATA_WIDTH'(total >> 1);
    endfunction

endpackage

// File: rtl/vol_variance_stage.sv
// Registered output stage: windowed mean and variance from running sums,
// clamped at zero, saturated to the output width and zeroed until the window is full.
module vol_variance_stage
    import rolling_volatility_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
    parameter int ID_W        = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic [ID_W-1:0]       i_stock_id,
    input  logic [CNT_W-1:0]      i_count,
    input  logic [SUM_W-1:0]      i_sum,
    input  logic [SQ_W-1:0]       i_sq,
    output logic [ID_W-1:0]       o_stock_id,
    output logic [DATA_WIDTH-1:0] o_volatility,
    output logic [DATA_WIDTH-1:0] o_mean,
    output logic                  o_warm,
    output logic                  o_data_valid
);

    localparam int N = 1 << WINDOW_LOG2;

    logic [SUM_W-1:0]      mean_full;
    logic [SQ_W-1:0]       q_avg;
    logic [SQ_W-1:0]       mean_sq;
    logic [SQ_W-1:0]       variance;
    logic [DATA_WIDTH-1:0] variance_sat;
    logic [DATA_WIDTH-1:0] mean;
    logic                  warm;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        mean_full = i_sum >> WINDOW_LOG2;
        q_avg     = i_sq >> WINDOW_LOG2;
        mean_sq   = SQ_W'(mean_full) * SQ_W'(mean_full);
        variance  = (q_avg > mean_sq) ? (q_avg - mean_sq) : '0;
        if (variance > SQ_W'({DATA_WIDTH{1'b1}})) begin
            variance_sat = '1;
        end else begin
            variance_sat = DATA_WIDTH'(variance);
        end
        mean = DATA_WIDTH'(mean_full);
        warm = (i_count == CNT_W'(N));
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_data_valid <= 1'b0;
            o_stock_id   <= '0;
            o_warm       <= 1'b0;
            o_mean       <= '0;
            o_volatility <= '0;
        end else begin
            o_data_valid <= i_valid;
            if (i_valid) begin
                o_stock_id   <= i_stock_id;
                o_warm       <= warm;
                o_mean       <= warm ? mean : '0;
                o_volatility <= warm ? variance_sat : '0;
            end
        end
    end

endmodule

// File: rtl/rolling_volatility.sv
// Per-stock rolling-window volatility engine: mid-price window per stock with
// incrementally maintained sum and sum of squares, two-cycle result latency.
module rolling_volatility
    import rolling_volatility_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_STOCKS  = DEF_NUM_STOCKS,
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic                          i_data_valid,
    input  logic                          i_flush,
    input  logic [DATA_WIDTH-1:0]         i_best_ask,
    input  logic [DATA_WIDTH-1:0]         i_best_bid,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_volatility,
    output logic [DATA_WIDTH-1:0]         o_mean,
    output logic                          o_warm,
    output logic                          o_data_valid
);

    localparam int N      = 1 << WINDOW_LOG2;
    localparam int ID_W   = $clog2(NUM_STOCKS);
    localparam int ADDR_W = ID_W + WINDOW_LOG2;
    localparam int DEPTH  = NUM_STOCKS * N;

    stock_state_t          state_q [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] sample_mem [DEPTH];

    logic                  accept;
    logic [DATA_WIDTH-1:0] mid;
    logic [DATA_WIDTH-1:0] old_mid;
    logic [ADDR_W-1:0]     addr;
    logic                  full;
    stock_state_t          base;
    stock_state_t          next_state;

    logic                  pipe_valid;
    logic [ID_W-1:0]       pipe_id;
    logic [CNT_W-1:0]      pipe_count;
    logic [SUM_W-1:0]      pipe_sum;
    logic [SQ_W-1:0]       pipe_sq;

    // A same-cycle flush is folded in by starting the update from an empty window.
    always_comb begin
        accept  = i_data_valid && (i_best_ask != '0) && (i_best_bid != '0);
        mid     = DATA_WIDTH'(mid_price(MAX_DATA_WIDTH'(i_best_ask), MAX_DATA_WIDTH'(i_best_bid)));
        base    = i_flush ? '0 : state_q[i_stock_id];
        full    = (base.count == CNT_W'(N));
        addr    = {i_stock_id, base.wr_ptr[WINDOW_LOG2-1:0]};
        old_mid = full ? sample_mem[addr] : '0;

        next_state.sum    = base.sum + SUM_W'(mid) - SUM_W'(old_mid);
        next_state.sq     = base.sq + SQ_W'(mid) * SQ_W'(mid)
                          - SQ_W'(old_mid) * SQ_W'(old_mid);
        next_state.wr_ptr = (base.wr_ptr + PTR_W'(1)) & PTR_W'(N - 1);
        next_state.count  = full ? base.count : (base.count + CNT_W'(1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int s = 0; s < NUM_STOCKS; s++) begin
                state_q[s] <= '0;
            end
        end else if (accept) begin
            state_q[i_stock_id] <= next_state;
        end else if (i_flush) begin
            state_q[i_stock_id] <= '0;
        end
    end

    // NOTE: the sample store is deliberately not reset; an entry is only read once count proves it was written.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && accept) begin
            sample_mem[addr] <= mid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pipe_valid <= 1'b0;
            pipe_id    <= '0;
            pipe_count <= '0;
            pipe_sum   <= '0;
            pipe_sq    <= '0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_id    <= i_stock_id;
                pipe_count <= next_state.count;
                pipe_sum   <= next_state.sum;
                pipe_sq    <= next_state.sq;
            end
        end
    end

    vol_variance_stage #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2),
        .ID_W        (ID_W)
    ) u_stage (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (pipe_valid),
        .i_stock_id   (pipe_id),
        .i_count      (pipe_count),
        .i_sum        (pipe_sum),
        .i_sq         (pipe_sq),
        .o_stock_id   (o_stock_id),
        .o_volatility (o_volatility),
        .o_mean       (o_mean),
        .o_warm       (o_warm),
        .o_data_valid (o_data_valid)
    );

endmodule
